// File: rtl/dma_io_pkg.sv
// Shared types and constants for the DMA I/O responder.
// Optional EOP-driving feature: DMA_IO_EOP_DRIVE_EN.
package dma_io_pkg;
    localparam int DATA_W = 8;
    localparam logic [DATA_W-1:0] DB_IDLE_BYTE = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ACK,
        STRB,
        DONE
    } state_e;
endpackage

// File: rtl/dma_io_fifo.sv
// Synchronous FIFO with occupancy count, first-word-fall-through head.
// Callers never push when full or pop when empty.
module dma_io_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             pushData,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;

    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= pushData;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rdPtr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
endmodule

// File: rtl/dma_io_responder.sv
// Peripheral side of an 8237-style DMA handshake with TX/RX byte FIFOs.
// Define DMA_IO_EOP_DRIVE_EN to add cfg_len and a self-driven EOP.
module dma_io_responder #(
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_W     = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              cfg_en,
    input  logic              cfg_dir,
    input  logic              cfg_single,
    input  logic              clr_status,
    output logic              DREQ,
    input  logic              DACK,
    input  logic              IOR_N,
    input  logic              IOW_N,
    input  logic              EOP_N,
    input  logic [DATA_W-1:0] DB_in,
    output logic [DATA_W-1:0] DB_out,
    output logic              DB_oe,
`ifdef DMA_IO_EOP_DRIVE_EN
    input  logic [15:0]       cfg_len,
    output logic              eop_n_oe,
`endif
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              eop_seen,
    output logic              overflow,
    output logic              underflow
);
    import dma_io_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e state, nextState;
    logic strbQ, dackQ, eopPending;
    logic [DATA_W-1:0] capQ, txHead;
    logic txPush, txPop, rxPush, rxPop;
    logic txFull, txEmpty, rxFull, rxEmpty;
    logic [CW-1:0] txCount, rxCount, txCntNext, rxCntNext;
    logic strobe, rise, busRise, commit, eligible, eligAfter;
    logic eopNow, lenHit, eopSet, dackFall, ovSet, ufSet;

    assign strobe   = cfg_dir ? IOW_N : IOR_N;
    assign rise     = strobe & ~strbQ;
    assign busRise  = cfg_en & DACK & rise;
    assign commit   = busRise & (state == STRB);
    assign dackFall = dackQ & ~DACK;
    assign eligible = cfg_en & ~eop_seen & (cfg_dir ? ~rxFull : ~txEmpty);

    assign txPush = tx_valid & ~txFull;
    assign txPop  = commit & ~cfg_dir & ~txEmpty;
    assign rxPush = commit & cfg_dir & ~rxFull;
    assign rxPop  = rx_ready & ~rxEmpty;
    // Stray strobes after DREQ drops still count as bus errors.
    assign ufSet  = busRise & ~cfg_dir & txEmpty;
    assign ovSet  = busRise & cfg_dir & rxFull;

    assign txCntNext = txCount + CW'(txPush) - CW'(txPop);
    assign rxCntNext = rxCount + CW'(rxPush) - CW'(rxPop);
    assign eligAfter = cfg_dir ? (rxCntNext < CW'(FIFO_DEPTH))
                               : (txCntNext != '0);

    assign eopNow = eopPending | (DACK & ~EOP_N) | lenHit;
    assign eopSet = (commit & eopNow) | (eopPending & dackFall);

    dma_io_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) txFifo (
        .clk(CLK), .rst(RESET),
        .push(txPush), .pushData(tx_data), .pop(txPop),
        .head(txHead), .count(txCount),
        .full(txFull), .empty(txEmpty)
    );

    dma_io_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) rxFifo (
        .clk(CLK), .rst(RESET),
        .push(rxPush), .pushData(capQ), .pop(rxPop),
        .head(rx_data), .count(rxCount),
        .full(rxFull), .empty(rxEmpty)
    );

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: if (eligible) nextState = REQ;
            REQ:  if (DACK) nextState = ACK;
            ACK: begin
                if (!DACK)        nextState = eligible ? REQ : IDLE;
                else if (!strobe) nextState = STRB;
            end
            STRB: begin
                if (!DACK) nextState = IDLE;
                else if (rise) begin
                    if (eopNow || cfg_single || !eligAfter) nextState = DONE;
                    else                                    nextState = ACK;
                end
            end
            DONE:    if (!DACK) nextState = IDLE;
            default: nextState = IDLE;
        endcase
        if (eopPending && dackFall) nextState = DONE;
        if (!cfg_en) nextState = IDLE;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            DREQ       <= 1'b0;
            strbQ      <= 1'b1;
            dackQ      <= 1'b0;
            eopPending <= 1'b0;
            capQ       <= '0;
            eop_seen   <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            state      <= nextState;
            DREQ       <= nextState inside {REQ, ACK, STRB};
            strbQ      <= strobe;
            dackQ      <= DACK;
            if (!IOW_N) capQ <= DB_in;
            eopPending <= ~eopSet & (eopPending |
                          (DACK & ~EOP_N & (state inside {REQ, ACK, STRB})));
            eop_seen   <= eopSet | (eop_seen & ~clr_status);
            overflow   <= ovSet | (overflow & ~clr_status);
            underflow  <= ufSet | (underflow & ~clr_status);
        end
    end

`ifdef DMA_IO_EOP_DRIVE_EN
    logic [16:0] lenLeft;

    always_ff @(posedge CLK) begin
        if (RESET) lenLeft <= '0;
        else if (state == IDLE && nextState == REQ)
            lenLeft <= (cfg_len == 16'd0) ? 17'h10000 : {1'b0, cfg_len};
        else if (commit && lenLeft != '0)
            lenLeft <= lenLeft - 1'b1;
    end

    assign lenHit   = (lenLeft == 17'd1);
    assign eop_n_oe = (state == STRB) & lenHit;
`else
    assign lenHit = 1'b0;
`endif

    assign tx_ready = ~txFull;
    assign rx_valid = ~rxEmpty;
    assign DB_oe    = ~RESET & ~cfg_dir & DACK & ~IOR_N;
    assign DB_out   = DB_oe ? (txEmpty ? DB_IDLE_BYTE : txHead) : '0;
endmodule

// File: tb/tb_dma_io_responder.sv
// Directed bench for dma_io_responder with a queue-based reference model.
// Covers DMA_IO_EOP_DRIVE_EN when that macro is defined.
module tb_dma_io_responder;
    logic CLK = 1'b0;
    logic RESET, cfg_en, cfg_dir, cfg_single, clr_status;
    logic DREQ, DACK, IOR_N, IOW_N, EOP_N, DB_oe;
    logic [7:0] DB_in, DB_out, tx_data, rx_data;
    logic tx_valid, tx_ready, rx_valid, rx_ready;
    logic eop_seen, overflow, underflow;
`ifdef DMA_IO_EOP_DRIVE_EN
    logic [15:0] cfg_len;
    logic eop_n_oe;
`endif

    int total = 0;
    int bad = 0;
    bit chk = 0;

    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic [7:0] mCap;
    bit mEopSeen, mOv, mUf;
    bit mCommit, mRise, mEop, expOe;

    dma_io_responder dut (
        .CLK(CLK), .RESET(RESET),
        .cfg_en(cfg_en), .cfg_dir(cfg_dir),
        .cfg_single(cfg_single), .clr_status(clr_status),
        .DREQ(DREQ), .DACK(DACK),
        .IOR_N(IOR_N), .IOW_N(IOW_N), .EOP_N(EOP_N),
        .DB_in(DB_in), .DB_out(DB_out), .DB_oe(DB_oe),
`ifdef DMA_IO_EOP_DRIVE_EN
        .cfg_len(cfg_len), .eop_n_oe(eop_n_oe),
`endif
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .eop_seen(eop_seen), .overflow(overflow), .underflow(underflow)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference model: FIFOs as queues, flags from bus-level intent.
    always @(posedge CLK) begin : model
        int txn, rxn;
        bit uf, ov;
        txn = txq.size();
        rxn = rxq.size();
        if (RESET) begin
            txq.delete();
            rxq.delete();
            mCap = 8'h00;
            mEopSeen = 0;
            mOv = 0;
            mUf = 0;
        end else begin
            uf = mRise && !cfg_dir && txn == 0;
            ov = mRise && cfg_dir && rxn == 16;
            if (mCommit && !cfg_dir && txn > 0) void'(txq.pop_front());
            if (mCommit && cfg_dir && rxn < 16) rxq.push_back(mCap);
            if (tx_valid && txn < 16) txq.push_back(tx_data);
            if (rx_ready && rxn > 0) void'(rxq.pop_front());
            if (!IOW_N) mCap = DB_in;
            mUf = uf | (mUf & !clr_status);
            mOv = ov | (mOv & !clr_status);
            mEopSeen = mEop | (mEopSeen & !clr_status);
        end
    end

    always @(posedge CLK) begin : cmp
        logic oe;
        logic [7:0] dbx;
        #1;
        if (chk) begin
            oe = !RESET && !cfg_dir && DACK && !IOR_N;
            dbx = !oe ? 8'h00 : (txq.size() > 0 ? txq[0] : 8'hFF);
            check("tx_ready", tx_ready, txq.size() < 16);
            check("rx_valid", rx_valid, rxq.size() > 0);
            if (rxq.size() > 0) check("rx_data", rx_data, rxq[0]);
            check("DB_oe", DB_oe, oe);
            check("DB_out", DB_out, dbx);
            check("eop_seen", eop_seen, mEopSeen);
            check("overflow", overflow, mOv);
            check("underflow", underflow, mUf);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic waitDreq(input logic v, input int budget,
                            input string name);
        for (int i = 0; i < budget && DREQ !== v; i++) @(negedge CLK);
        check(name, DREQ, v);
    endtask

    task automatic pushTx(input logic [7:0] d);
        tx_valid = 1;
        tx_data = d;
        @(negedge CLK);
        tx_valid = 0;
    endtask

    task automatic pulseClr();
        clr_status = 1;
        @(negedge CLK);
        clr_status = 0;
    endtask

    task automatic strobeCycle(input logic [7:0] d, input bit commit,
                               input bit eop);
        if (cfg_dir) begin
            IOW_N = 0;
            DB_in = d;
        end else begin
            IOR_N = 0;
        end
        EOP_N = !eop;
        @(negedge CLK);
        if (!cfg_dir) begin
            check("strobe_oe", DB_oe, 1);
            check("strobe_db", DB_out, d);
        end
`ifdef DMA_IO_EOP_DRIVE_EN
        check("eop_n_oe", eop_n_oe, expOe);
`endif
        IOR_N = 1;
        IOW_N = 1;
        EOP_N = 1;
        mCommit = commit;
        mRise = DACK;
        mEop = (eop | expOe) & commit;
        @(negedge CLK);
        mCommit = 0;
        mRise = 0;
        mEop = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: no finish by time %0t", $time);
        $fatal(1);
    end

    initial begin
        RESET = 1; cfg_en = 0; cfg_dir = 0; cfg_single = 0;
        clr_status = 0; DACK = 0; IOR_N = 1; IOW_N = 1; EOP_N = 1;
        DB_in = 0; tx_valid = 0; tx_data = 0; rx_ready = 0;
        mCommit = 0; mRise = 0; mEop = 0; expOe = 0;
`ifdef DMA_IO_EOP_DRIVE_EN
        cfg_len = 0;
`endif
        chk = 1;
        tick(3);
        check("rst_dreq", DREQ, 0);
        check("rst_oe", DB_oe, 0);
        check("rst_db", DB_out, 8'h00);
        check("rst_rxv", rx_valid, 0);
        check("rst_txr", tx_ready, 1);
        check("rst_stat", {eop_seen, overflow, underflow}, 3'b000);
        RESET = 0;

        // T1: device->memory, demand mode, three bytes back to back
        pushTx(8'hA1); pushTx(8'hA2); pushTx(8'hA3);
        cfg_en = 1;
        waitDreq(1, 5, "t1_req");
        DACK = 1; tick(1);
        strobeCycle(8'hA1, 1, 0); check("t1_dreq1", DREQ, 1);
        strobeCycle(8'hA2, 1, 0); check("t1_dreq2", DREQ, 1);
        strobeCycle(8'hA3, 1, 0); check("t1_dreq3", DREQ, 0);
        strobeCycle(8'hFF, 0, 0);
        check("t1_uflow", underflow, 1);
        DACK = 0; pulseClr(); tick(2);
        check("t1_idle", DREQ, 0);
        check("t1_uclr", underflow, 0);

        // T2: memory->device, single mode
        cfg_dir = 1; cfg_single = 1;
        waitDreq(1, 5, "t2_req1");
        DACK = 1; tick(1);
        strobeCycle(8'h5C, 1, 0); check("t2_drop1", DREQ, 0);
        DACK = 0; tick(1);
        waitDreq(1, 5, "t2_req2");
        DACK = 1; tick(1);
        strobeCycle(8'h3E, 1, 0); check("t2_drop2", DREQ, 0);
        DACK = 0; cfg_en = 0; tick(1);
        check("t2_rx0", rx_data, 8'h5C);
        rx_ready = 1; tick(1); rx_ready = 0;
        check("t2_rx1", rx_data, 8'h3E);
        rx_ready = 1; tick(1); rx_ready = 0;
        check("t2_empty", rx_valid, 0);

        // T3: fill RX, then one extra strobe overflows
        cfg_single = 0; cfg_en = 1;
        waitDreq(1, 5, "t3_req");
        DACK = 1; tick(1);
        for (int i = 0; i < 16; i++) strobeCycle(8'(8'h10 + i), 1, 0);
        check("t3_full_dreq", DREQ, 0);
        check("t3_no_ovf", overflow, 0);
        strobeCycle(8'hEE, 0, 0);
        check("t3_ovf", overflow, 1);
        DACK = 0; cfg_en = 0; tick(1);
        check("t3_head", rx_data, 8'h10);
        pulseClr();
        check("t3_oclr", overflow, 0);
        rx_ready = 1; tick(16); rx_ready = 0;
        check("t3_drained", rx_valid, 0);

        // T4: EOP during the second of four reads
        cfg_dir = 0;
        pushTx(8'hB1); pushTx(8'hB2); pushTx(8'hB3); pushTx(8'hB4);
        cfg_en = 1;
        waitDreq(1, 5, "t4_req");
        DACK = 1; tick(1);
        strobeCycle(8'hB1, 1, 0); check("t4_dreq1", DREQ, 1);
        strobeCycle(8'hB2, 1, 1); check("t4_dreq_eop", DREQ, 0);
        check("t4_eop", eop_seen, 1);
        DACK = 0; tick(4);
        check("t4_hold", DREQ, 0);
        pulseClr();
        waitDreq(1, 5, "t4_rearm");
        check("t4_eclr", eop_seen, 0);

        // T5: DACK drops mid-strobe, byte B3 must survive
        DACK = 1; tick(1);
        IOR_N = 0; tick(1);
        check("t5_head", DB_out, 8'hB3);
        DACK = 0; tick(1);
        check("t5_abort", DREQ, 0);
        IOR_N = 1;
        waitDreq(1, 5, "t5_rereq");
        DACK = 1; tick(1);
        strobeCycle(8'hB3, 1, 0);
        strobeCycle(8'hB4, 1, 0);
        check("t5_done", DREQ, 0);
        DACK = 0; cfg_en = 0; tick(1);

        // T6: reset in the middle of a strobe
        pushTx(8'hC1); pushTx(8'hC2);
        cfg_en = 1;
        waitDreq(1, 5, "t6_req");
        DACK = 1; tick(1);
        IOR_N = 0; tick(1);
        RESET = 1; tick(1);
        check("t6_dreq", DREQ, 0);
        check("t6_oe", DB_oe, 0);
        check("t6_db", DB_out, 8'h00);
        RESET = 0; DACK = 0; IOR_N = 1; tick(3);
        check("t6_empty", DREQ, 0);

`ifdef DMA_IO_EOP_DRIVE_EN
        cfg_len = 16'd2;
        pushTx(8'hD1); pushTx(8'hD2); pushTx(8'hD3);
        waitDreq(1, 5, "t6_len_req");
        DACK = 1; tick(1);
        expOe = 0; strobeCycle(8'hD1, 1, 0);
        expOe = 1; strobeCycle(8'hD2, 1, 0);
        expOe = 0;
        check("t6_len_dreq", DREQ, 0);
        check("t6_len_eop", eop_seen, 1);
        DACK = 0; cfg_en = 0; tick(2);
`endif

        chk = 0;
        tick(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
